// File: rtl/serial_wide_adder_ctrl_if.sv
// Stream and adder-side bundle for serial_wide_adder_ctrl.
// SERIAL_ADDER_OVERFLOW_EN adds the out_ovf signal.
interface serial_wide_adder_ctrl_if #(
  parameter int NUM_SLICES = 4
);
  localparam int W = 6 * NUM_SLICES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic [5:0]   add_x;
  logic [5:0]   add_y;
  logic         add_cin;
  logic [6:0]   add_s;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic         out_ovf;
`endif

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    output in_cin,
    output out_ready,
    output add_s,
    input  in_ready,
    input  add_x,
    input  add_y,
    input  add_cin,
    input  out_valid,
    input  out_sum,
    input  out_cout
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    input  out_ovf
`endif
  );

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    input  in_cin,
    input  out_ready,
    input  add_s,
    output in_ready,
    output add_x,
    output add_y,
    output add_cin,
    output out_valid,
    output out_sum,
    output out_cout
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    output out_ovf
`endif
  );
endinterface

// File: rtl/serial_wide_adder_ctrl.sv
// Wide adder sequencer: one 6-bit slice per cycle through an external adder.
// Optional signed overflow flag under SERIAL_ADDER_OVERFLOW_EN.
module serial_wide_adder_ctrl #(
  parameter int NUM_SLICES = 4
) (
  input logic                clk,
  input logic                rst_n,
  serial_wide_adder_ctrl_if.slave bus
);
  localparam int CW = $clog2(NUM_SLICES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic [NUM_SLICES-1:0][5:0] slices_t;

  state_e        state_q, state_d;
  slices_t       a_q, a_d;
  slices_t       b_q, b_d;
  slices_t       sum_q, sum_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic          ovf_q, ovf_d;
`endif

  assign last = (cnt_q == CW'(NUM_SLICES - 1));

  always_comb begin
    bus.add_x   = '0;
    bus.add_y   = '0;
    bus.add_cin = 1'b0;
    if (state_q == RUN) begin
      bus.add_x   = a_q[cnt_q];
      bus.add_y   = b_q[cnt_q];
      bus.add_cin = carry_q;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    unique case (1'b1)
      (state_q == IDLE): begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          carry_d = bus.in_cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      (state_q == RUN): begin
        sum_d[cnt_q] = bus.add_s[5:0];
        carry_d      = bus.add_s[6];
        if (last) begin
          cout_d  = bus.add_s[6];
`ifdef SERIAL_ADDER_OVERFLOW_EN
          // carry into MSB xor carry out of MSB
          ovf_d   = bus.add_s[5] ^ bus.add_x[5]
                  ^ bus.add_y[5] ^ bus.add_s[6];
`endif
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      (state_q == DONE): begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  assign bus.out_ovf   = ovf_q;
`endif
endmodule

// File: tb/tb_serial_wide_adder_ctrl.sv
// Directed bench for serial_wide_adder_ctrl with a behavioural 6-bit adder.
// Overflow checks compile in with SERIAL_ADDER_OVERFLOW_EN.
module tb_serial_wide_adder_ctrl;
  localparam int NS = 4;
  localparam int W  = 6 * NS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  serial_wide_adder_ctrl_if #(.NUM_SLICES(NS)) bus ();

  assign bus.add_s = {1'b0, bus.add_x} + {1'b0, bus.add_y}
                   + {6'd0, bus.add_cin};

  serial_wide_adder_ctrl #(.NUM_SLICES(NS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".out_sum"}, 32'(bus.out_sum), 32'd0);
    chk({tag, ".out_cout"}, 32'(bus.out_cout), 32'd0);
    chk({tag, ".add_x"}, 32'(bus.add_x), 32'd0);
    chk({tag, ".add_y"}, 32'(bus.add_y), 32'd0);
    chk({tag, ".add_cin"}, 32'(bus.add_cin), 32'd0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
    chk({tag, ".out_ovf"}, 32'(bus.out_ovf), 32'd0);
`endif
  endtask

  task automatic accept(input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic cin);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Checks each RUN cycle's adder drive against an independent ripple.
  task automatic run_slices(input string tag,
                            input logic [W-1:0] a,
                            input logic [W-1:0] b,
                            input logic cin,
                            input int n);
    logic       c;
    logic [6:0] s;
    c = cin;
    for (int i = 0; i < n; i++) begin
      chk({tag, ".run_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, ".run_ready"}, 32'(bus.in_ready), 32'd0);
      chk({tag, ".add_x"}, 32'(bus.add_x), 32'(a[6*i+:6]));
      chk({tag, ".add_y"}, 32'(bus.add_y), 32'(b[6*i+:6]));
      chk({tag, ".add_cin"}, 32'(bus.add_cin), 32'(c));
      s = {1'b0, a[6*i+:6]} + {1'b0, b[6*i+:6]} + {6'd0, c};
      c = s[6];
      tick();
    end
  endtask

  task automatic chk_done(input string tag,
                          input logic [W-1:0] sum,
                          input logic cout);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd0);
    chk({tag, ".add_x"}, 32'(bus.add_x), 32'd0);
    chk({tag, ".out_sum"}, 32'(bus.out_sum), 32'(sum));
    chk({tag, ".out_cout"}, 32'(bus.out_cout), 32'(cout));
  endtask

  task automatic drain(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, ".drain_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".drain_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic txn(input string tag,
                     input logic [W-1:0] a,
                     input logic [W-1:0] b,
                     input logic cin,
                     input logic [W-1:0] sum,
                     input logic cout);
    accept(a, b, cin);
    run_slices(tag, a, b, cin, NS);
    chk_done(tag, sum, cout);
    drain(tag);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    chk_reset_outs("rst");
    #4 rst_n = 1'b1;
    tick();
    chk_reset_outs("post_rst");

    txn("t1", 24'h000001, 24'h000001, 1'b0, 24'h000002, 1'b0);
    txn("t2", 24'hFFFFFF, 24'h000000, 1'b1, 24'h000000, 1'b1);
    txn("t3a", 24'h123456, 24'h654321, 1'b0, 24'h777777, 1'b0);
    txn("t3b", 24'hFFFFFF, 24'hFFFFFF, 1'b1, 24'hFFFFFF, 1'b1);

    accept(24'h000FFF, 24'h000001, 1'b0);
    run_slices("t4", 24'h000FFF, 24'h000001, 1'b0, NS);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0] ? 1'b0 : 1'b1;
      bus.in_a     = 24'hABCDEF + 24'(i);
      bus.in_b     = 24'h111111;
      tick();
      chk_done("t4.hold", 24'h001000, 1'b0);
    end
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("t4.both_valid", 32'(bus.out_valid), 32'd0);
    chk("t4.both_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("t4.no_accept", 32'(bus.in_ready), 32'd1);

    accept(24'h123456, 24'h111111, 1'b0);
    run_slices("t5", 24'h123456, 24'h111111, 1'b0, 2);
    chk("t5.partial", 32'(bus.out_sum[11:0] != 12'd0), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("t5.async");
    #3 rst_n = 1'b1;
    tick();
    chk_reset_outs("t5.release");
    txn("t5b", 24'h00003F, 24'h000001, 1'b0, 24'h000040, 1'b0);

`ifdef SERIAL_ADDER_OVERFLOW_EN
    accept(24'h7FFFFF, 24'h000001, 1'b0);
    run_slices("t6a", 24'h7FFFFF, 24'h000001, 1'b0, NS);
    chk_done("t6a", 24'h800000, 1'b0);
    chk("t6a.ovf", 32'(bus.out_ovf), 32'd1);
    drain("t6a");
    accept(24'hFFFFFF, 24'h000001, 1'b0);
    run_slices("t6b", 24'hFFFFFF, 24'h000001, 1'b0, NS);
    chk_done("t6b", 24'h000000, 1'b1);
    chk("t6b.ovf", 32'(bus.out_ovf), 32'd0);
    drain("t6b");
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/serial_wide_adder_ctrl.md
Name: serial_wide_adder_ctrl

Overview:
Sequencer that performs wide (6*NUM_SLICES-bit) additions by time-multiplexing the 6-bit prefix adder, one slice per cycle, LSB slice first. It sits on both sides of the adder. It drives the adder's operands and carry-in, and captures the adder's 7-bit result, feeding the slice carry (S[6]) back as the next carry-in. Upstream and downstream interfaces are valid/ready streams.

Parameters:
NUM_SLICES, 4, number of 6-bit slices per operand (operand width W = 6*NUM_SLICES = 24 by default); legal range 2..16.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands
in_a  in  W  operand A
in_b  in  W  operand B
in_cin  in  1  carry-in for the whole addition
add_x  out  6  to adder X
add_y  out  6  to adder Y
add_cin  out  1  to adder c_in
add_s  in  7  from adder S; S[5:0] sum slice, S[6] slice carry-out
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_sum  out  W  wide sum
out_cout  out  1  final carry-out

Behaviour:
- Adder contract: add_s = add_x + add_y + add_cin, purely combinational, settles within the same cycle. add_* are driven from registers and the slice counter only.
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: in_ready=1 (IDLE), out_valid=0, out_sum=0, out_cout=0, add_x=0, add_y=0, add_cin=0. Internal operand, carry and counter registers reset to 0.
- IDLE:
  - in_ready=1, add_* driven 0.
  - On in_valid&&in_ready: latch in_a, in_b, and in_cin (into the carry register); cnt<=0; go to RUN.
- RUN:
  - in_ready=0; in_valid is ignored.
  - add_x = A[6*cnt+:6], add_y = B[6*cnt+:6], add_cin = carry register.
  - Each clock: out_sum[6*cnt+:6] <= add_s[5:0]; carry <= add_s[6].
  - If cnt==NUM_SLICES-1: out_cout <= add_s[6] and go to DONE. Otherwise cnt <= cnt+1.
- DONE:
  - out_valid=1, in_ready=0, add_* driven 0. out_sum and out_cout are held stable.
  - On out_ready: out_valid falls on the next edge; go to IDLE.
- Latency: accept at edge k; out_valid is high after edge k+NUM_SLICES.
- Throughput: one result per NUM_SLICES+2 cycles minimum (IDLE, NUM_SLICES RUN cycles, DONE with out_ready=1).
- out_sum slices update progressively during RUN. Downstream must sample only when out_valid=1.
- Counter width: clog2(NUM_SLICES). The wrap-around at the top slice is never reached; the transition to DONE takes precedence.
- Simultaneous out_ready and in_valid in DONE: the result handshake completes. The new operand is not accepted until the following IDLE cycle (no bypass).
- Reset asserted mid-RUN or mid-DONE: immediate return to IDLE, all outputs take reset values, the in-flight transaction is discarded.
- Carry chaining: the carry flows only through the adder. This block performs no arithmetic of its own except the optional flag.

Optional Feature:
- Macro: SERIAL_ADDER_OVERFLOW_EN.
- When defined:
  - Extra output port out_ovf, 1 bit, reset 0.
  - Signed two's-complement overflow of the W-bit addition.
  - Computed on the final RUN cycle as (add_s[5]^add_x[5]^add_y[5]) ^ add_s[6], i.e. carry into the MSB xor carry out of the MSB.
  - Registered alongside out_cout, held in DONE, cleared on reset.
- When undefined: port absent, no extra logic.

Test Plan:
1. NUM_SLICES=4; in_a=0x000001, in_b=0x000001, in_cin=0 -> out_sum=0x000002, out_cout=0; out_valid rises exactly 4 cycles after the accept edge.
2. in_a=0xFFFFFF, in_b=0x000000, in_cin=1 -> carry ripples through all slices (add_cin=1 on each RUN cycle); out_sum=0x000000, out_cout=1.
3. in_a=0x123456, in_b=0x654321, in_cin=0 -> out_sum=0x777777, out_cout=0. Then in_a=0xFFFFFF, in_b=0xFFFFFF, in_cin=1 back-to-back -> out_sum=0xFFFFFF, out_cout=1.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands -> out_valid stays 1, out_sum/out_cout stable, in_ready=0, new operands not accepted. Then out_ready=1 -> IDLE next cycle.
5. Assert rst_n=0 after 2 RUN cycles -> all outputs return to reset values asynchronously. After release, in_ready=1 and the next transaction 0x00003F+0x000001 gives out_sum=0x000040.
6. With SERIAL_ADDER_OVERFLOW_EN: 0x7FFFFF+0x000001 -> out_sum=0x800000, out_ovf=1, out_cout=0. Also 0xFFFFFF+0x000001 -> out_sum=0, out_ovf=0, out_cout=1.
